// File: rtl/mult_host_pkg.sv
// Shared types and constants for the multiplier host: FSM state encoding,
// bus function codes and a counter-width helper.
package mult_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_M,
    WR_Q,
    START,
    WAIT,
    RD_LO,
    RD_HI,
    DONE
  } state_t;

  localparam logic [1:0] FUNC_WR_M  = 2'b00;
  localparam logic [1:0] FUNC_WR_Q  = 2'b01;
  localparam logic [1:0] FUNC_RD_LO = 2'b10;
  localparam logic [1:0] FUNC_RD_HI = 2'b11;

  // One counter serves every timed phase, so size it for the longest load value.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mult_host_if.sv
// Host-side request/response handshake plus the multiplier control lines.
// The shared data bus stays a plain inout on the top module.
interface mult_host_if #(
  parameter int N = 8
);
  logic           req;
  logic [N-1:0]   opA;
  logic [N-1:0]   opB;
  logic           busy;
  logic           done;
  logic           error;
  logic [2*N-1:0] product;
  logic [1:0]     func;
  logic           oe;
  logic           start;
  logic           ready;

  modport master (
    input  req, opA, opB, ready,
    output busy, done, error, product, func, oe, start
  );

  modport slave (
    output req, opA, opB, ready,
    input  busy, done, error, product, func, oe, start
  );
endinterface

// File: rtl/mult_host_hold_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module hold_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mult_host.sv
// Bus master for the multiplier: writes M/Q, holds start past the debouncer,
// waits for ready (with timeout) and reads back the two product halves.
module mult_host
  import mult_host_pkg::*;
#(
  parameter int N          = 8,
  parameter int START_HOLD = 250000,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        nReset,
  mult_host_if.master bus,
  inout  wire [N-1:0] data
);

  localparam int CW = cnt_width(START_HOLD, TIMEOUT);

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_product;
  logic           r_error;

  logic           w_ld;
  logic [CW-1:0]  w_ld_val;
  logic           w_dec;
  logic           w_zero;
  logic [1:0]     w_func;

  hold_counter #(.W(CW)) u_hold (
    .clock      (clock),
    .nReset     (nReset),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // The counter is loaded on the transition into each timed state, so the
  // state's first cycle already sees the full count.
  always_comb begin
    w_state_next = r_state;
    w_ld         = 1'b0;
    w_ld_val     = '0;
    w_dec        = 1'b0;
    case (r_state)
      IDLE:  if (bus.req) w_state_next = WR_M;
      WR_M:  w_state_next = WR_Q;
      WR_Q: begin
        w_state_next = START;
        w_ld         = 1'b1;
        w_ld_val     = CW'(START_HOLD - 1);
      end
      START: begin
        if (w_zero) begin
          w_state_next = WAIT;
          w_ld         = 1'b1;
          w_ld_val     = CW'(TIMEOUT - 1);
        end else begin
          w_dec = 1'b1;
        end
      end
      WAIT: begin
        if (bus.ready) begin
          w_state_next = RD_LO;
          w_ld         = 1'b1;
          w_ld_val     = CW'(1);
        end else if (w_zero) begin
          w_state_next = DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      RD_LO: begin
        if (w_zero) begin
          w_state_next = RD_HI;
          w_ld         = 1'b1;
          w_ld_val     = CW'(1);
        end else begin
          w_dec = 1'b1;
        end
      end
      RD_HI: begin
        if (w_zero) w_state_next = DONE;
        else        w_dec = 1'b1;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Each read half is sampled on the second cycle of its phase, leaving the
  // first cycle as bus turnaround.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req) begin
          r_a       <= bus.opA;
          r_b       <= bus.opB;
          r_product <= '0;
          r_error   <= 1'b0;
        end
        WAIT:  if (!bus.ready && w_zero) r_error <= 1'b1;
        RD_LO: if (w_zero) r_product[N-1:0]   <= data;
        RD_HI: if (w_zero) r_product[2*N-1:N] <= data;
        default: ;
      endcase
    end
  end

  // 00/01 make the multiplier load M/Q every clock, so only the write states use them.
  always_comb begin
    w_func = FUNC_RD_HI;
    case (r_state)
      WR_M:    w_func = FUNC_WR_M;
      WR_Q:    w_func = FUNC_WR_Q;
      RD_LO:   w_func = FUNC_RD_LO;
      default: w_func = FUNC_RD_HI;
    endcase
  end

  assign bus.func    = w_func;
  assign bus.oe      = (r_state == RD_LO) || (r_state == RD_HI);
  assign bus.start   = (r_state == START);
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = (r_state == DONE);
  assign bus.error   = r_error;
  assign bus.product = r_product;

  assign data = (r_state == WR_M) ? r_a :
                (r_state == WR_Q) ? r_b : {N{1'bz}};

endmodule

// File: tb/tb_mult_host.sv
// Scoreboard bench for mult_host against a small behavioural multiplier
// that latches M/Q from the bus and drives the product halves when oe is high.
module tb_mult_host;
  import mult_host_pkg::*;

  localparam int N  = 8;
  localparam int SH = 4;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  wire [N-1:0] data;
  mult_host_if #(.N(N)) hif();

  mult_host #(.N(N), .START_HOLD(SH), .TIMEOUT(TO)) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (hif),
    .data   (data)
  );

  // Behavioural multiplier on the far side of the bus.
  logic [N-1:0]   m_reg = '0;
  logic [N-1:0]   q_reg = '0;
  logic           ready_en = 1'b1;
  logic [2*N-1:0] m_prod;
  assign m_prod = {8'b0, m_reg} * {8'b0, q_reg};

  always @(posedge clock) begin
    if (hif.func == FUNC_WR_M)      m_reg <= data;
    else if (hif.func == FUNC_WR_Q) q_reg <= data;
  end

  assign data = hif.oe ? ((hif.func == FUNC_RD_LO) ? m_prod[7:0] : m_prod[15:8]) : 8'bz;
  assign hif.ready = ready_en;

  typedef struct {
    logic [15:0] prod;
    logic        err;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    int          rd;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: per-transaction bus activity and scoreboard comparison on done.
  int         since, wrm_n, wrq_n, st_n, rdlo_n, rdhi_n, viol;
  logic [7:0] wrm_d, wrq_d;
  logic       prev_busy, prev_oe;
  logic [1:0] prev_func;

  initial begin
    exp_t e;
    logic host_drv, prev_drv;
    since = 0; wrm_n = 0; wrq_n = 0; st_n = 0; rdlo_n = 0; rdhi_n = 0; viol = 0;
    wrm_d = '0; wrq_d = '0;
    prev_busy = 1'b0; prev_oe = 1'b0; prev_func = FUNC_RD_HI;
    forever begin
      @(negedge clock);
      if (hif.busy && !prev_busy) begin
        since = 1; wrm_n = 0; wrq_n = 0; st_n = 0; rdlo_n = 0; rdhi_n = 0; viol = 0;
      end else begin
        since++;
      end
      host_drv = (hif.func == FUNC_WR_M) || (hif.func == FUNC_WR_Q);
      prev_drv = (prev_func == FUNC_WR_M) || (prev_func == FUNC_WR_Q);
      if (host_drv && !hif.busy)           viol++;
      if (hif.oe && host_drv)              viol++;
      if (hif.oe && !prev_oe && prev_drv)  viol++;
      if (hif.func == FUNC_WR_M) begin wrm_n++; wrm_d = data; end
      if (hif.func == FUNC_WR_Q) begin wrq_n++; wrq_d = data; end
      if (hif.start) st_n++;
      if (hif.oe && hif.func == FUNC_RD_LO) rdlo_n++;
      if (hif.oe && hif.func == FUNC_RD_HI) rdhi_n++;
      if (hif.done) begin
        done_cnt++;
        check("sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("txn %0d: A=%02h B=%02h product=%04h error=%0b latency=%0d",
                   done_cnt, e.a, e.b, hif.product, hif.error, since);
          check("product", hif.product, e.prod);
          check("error", hif.error, e.err);
          check("latency", since, e.lat);
          check("wr_m_cycles", wrm_n, 1);
          check("wr_m_data", wrm_d, e.a);
          check("wr_q_cycles", wrq_n, 1);
          check("wr_q_data", wrq_d, e.b);
          check("start_cycles", st_n, SH);
          check("rd_lo_cycles", rdlo_n, e.rd);
          check("rd_hi_cycles", rdhi_n, e.rd);
          check("contention", viol, 0);
        end
      end
      prev_busy = hif.busy;
      prev_oe   = hif.oe;
      prev_func = hif.func;
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push,
                       input logic [15:0] p, input logic err, input int lat, input int rd);
    exp_t e;
    @(negedge clock);
    hif.opA = a;
    hif.opB = b;
    hif.req = 1'b1;
    if (push) begin
      e.prod = p; e.err = err; e.a = a; e.b = b; e.lat = lat; e.rd = rd;
      sb.push_back(e);
    end
    @(negedge clock);
    hif.req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("done_within_bound", 32'(done_cnt >= target), 1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int k;
    hif.req = 1'b0;
    hif.opA = '0;
    hif.opB = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", hif.busy, 0);
    check("rst_done", hif.done, 0);
    check("rst_error", hif.error, 0);
    check("rst_product", hif.product, 0);
    check("rst_func", hif.func, FUNC_RD_HI);
    check("rst_oe", hif.oe, 0);
    check("rst_start", hif.start, 0);
    nReset = 1'b1;

    issue(8'h0C, 8'h0A, 1'b1, 16'h0078, 1'b0, 12, 2);
    wait_done(1);
    issue(8'hFF, 8'hFF, 1'b1, 16'hFE01, 1'b0, 12, 2);
    wait_done(2);

    // Ready never arrives: timeout after TO wait cycles, no reads.
    ready_en = 1'b0;
    issue(8'h12, 8'h34, 1'b1, 16'h0000, 1'b1, 23, 0);
    wait_done(3);
    ready_en = 1'b1;
    issue(8'h11, 8'h11, 1'b1, 16'h0121, 1'b0, 12, 2);
    wait_done(4);

    // Async reset in the middle of the start hold.
    issue(8'h55, 8'h66, 1'b0, 16'h0, 1'b0, 0, 0);
    k = 0;
    while (!hif.start && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("start_seen", hif.start, 1);
    @(posedge clock);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_start", hif.start, 0);
    check("mid_rst_busy", hif.busy, 0);
    check("mid_rst_oe", hif.oe, 0);
    check("mid_rst_func", hif.func, FUNC_RD_HI);
    @(negedge clock);
    nReset = 1'b1;
    issue(8'h07, 8'h09, 1'b1, 16'h003F, 1'b0, 12, 2);
    wait_done(5);

    // A second request while busy must be dropped.
    issue(8'h03, 8'h05, 1'b1, 16'h000F, 1'b0, 12, 2);
    @(negedge clock);
    hif.opA = 8'hFF;
    hif.opB = 8'hFF;
    hif.req = 1'b1;
    @(negedge clock);
    hif.req = 1'b0;
    wait_done(6);
    repeat (20) @(negedge clock);
    check("done_count", done_cnt, 6);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
